tx_pattern_gen: RTL and testbench

TX_PATTERN_GEN -- requirements
Module: tx_pattern_gen

---
 rtl/tx_pattern_gen.sv | 184 ++++++++++++++++++
 tb/tb_tx_pattern_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tx_pattern_gen.sv
// tx_pattern_gen
// Serial test-pattern source running at one bit (UI) per rising clock edge.
// It can emit a single delayed pulse, a PRBS7 stream or a clock pattern.
// Every output is a register.
//
// Ports
//   clk      bit clock, one UI per rising edge
//   rst      synchronous active-high reset
//   start    launch request, looked at only while idle
//   mode     00 none, 01 single pulse, 10 PRBS7, 11 clock pattern
//   nbits    bits to emit in PRBS7/clock modes, 0 = continuous
//   stop     abort the running sequence
//   err_inj  invert the bit emitted on this edge (PRBS7/clock only)
//   out      registered serial bit, idles at B0
//   busy     high while a sequence is active
//   done     one-cycle completion strobe
//   bit_cnt  bits emitted in the current/last run, saturating
module tx_pattern_gen #(
  parameter logic       B0    = 1'b0,
  parameter int         TD_UI = 25,
  parameter int         TW_UI = 1,
  parameter logic [6:0] SEED  = 7'h7F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [15:0] nbits,
  input  logic        stop,
  input  logic        err_inj,
  output logic        out,
  output logic        busy,
  output logic        done,
  output logic [15:0] bit_cnt
);

  // An all-zero seed would lock the LFSR up, so it is replaced by 1.
  localparam logic [6:0] SEED_EFF = (SEED == 7'h00) ? 7'h01 : SEED;

  // The wait counter runs 0..TD_UI-1 while in WAIT.
  localparam int              WCW       = (TD_UI > 1) ? $clog2(TD_UI) : 1;
  localparam logic [WCW-1:0]  WAIT_LAST = (TD_UI > 0) ? WCW'(TD_UI - 1) : '0;
  localparam logic [15:0]     TW_LAST   = 16'(TW_UI);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    PULSE,
    RUN,
    DONE
  } state_t;

  state_t         state, state_d;
  logic           out_d, busy_d, done_d;
  logic [15:0]    cnt_d, cnt_inc;
  logic [6:0]     lfsr, lfsr_d;
  logic           prbs_bit;
  logic [WCW-1:0] wait_cnt, wait_d;
  logic           phase, phase_d;
  logic [1:0]     mode_r, mode_d;
  logic [15:0]    nbits_r, nbits_d;

  // Helper terms shared by the next-state logic: the saturating bit count
  // and the PRBS7 feedback bit (x^7 + x^6 + 1).
  always_comb begin
    cnt_inc  = (bit_cnt == 16'hFFFF) ? bit_cnt : bit_cnt + 16'd1;
    prbs_bit = lfsr[6] ^ lfsr[5];
  end

  // Next-state and next-output logic. The registered outputs are computed
  // from the state present before the edge, so the launch edge still shows
  // idle outputs and the sequence becomes visible one edge later. stop is
  // checked first in every active state so that it beats a final bit.
  always_comb begin
    state_d = state;
    out_d   = B0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    cnt_d   = bit_cnt;
    lfsr_d  = lfsr;
    wait_d  = wait_cnt;
    phase_d = phase;
    mode_d  = mode_r;
    nbits_d = nbits_r;
    case (state)
      IDLE: begin
        if (start && (mode != 2'b00)) begin
          mode_d  = mode;
          nbits_d = nbits;
          cnt_d   = 16'd0;
          lfsr_d  = SEED_EFF;
          wait_d  = '0;
          phase_d = 1'b0;
          if (mode == 2'b01) begin
            state_d = (TD_UI == 0) ? PULSE : WAIT;
          end else begin
            state_d = RUN;
          end
        end
      end
      WAIT: begin
        if (stop) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          busy_d = 1'b1;
          wait_d = wait_cnt + 1'b1;
          if (wait_cnt == WAIT_LAST) begin
            state_d = PULSE;
          end
        end
      end
      PULSE: begin
        if (stop) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          busy_d = 1'b1;
          out_d  = ~B0;
          cnt_d  = cnt_inc;
          if (cnt_inc == TW_LAST) begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (stop) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          busy_d = 1'b1;
          cnt_d  = cnt_inc;
          // err_inj only touches the emitted bit, never the LFSR or phase.
          if (mode_r == 2'b10) begin
            out_d  = prbs_bit ^ err_inj;
            lfsr_d = {lfsr[5:0], prbs_bit};
          end else begin
            out_d   = (phase ? B0 : ~B0) ^ err_inj;
            phase_d = ~phase;
          end
          if ((nbits_r != 16'd0) && (cnt_inc == nbits_r)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset drops everything back to idle without
  // a done strobe and reloads the seed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      out      <= B0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bit_cnt  <= 16'd0;
      lfsr     <= SEED_EFF;
      wait_cnt <= '0;
      phase    <= 1'b0;
      mode_r   <= 2'b00;
      nbits_r  <= 16'd0;
    end else begin
      state    <= state_d;
      out      <= out_d;
      busy     <= busy_d;
      done     <= done_d;
      bit_cnt  <= cnt_d;
      lfsr     <= lfsr_d;
      wait_cnt <= wait_d;
      phase    <= phase_d;
      mode_r   <= mode_d;
      nbits_r  <= nbits_d;
    end
  end

endmodule

// File: tb/tb_tx_pattern_gen.sv
// tb_tx_pattern_gen
// Directed bench for tx_pattern_gen with default parameters (B0=0,
// TD_UI=25, TW_UI=1, SEED=7F). Inputs are driven on the falling edge and
// outputs are sampled on the following falling edge.
module tb_tx_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] nbits;
  logic        stop;
  logic        err_inj;
  logic        out;
  logic        busy;
  logic        done;
  logic [15:0] bit_cnt;

  int checks = 0;
  int errors = 0;

  logic ref_bits [1:300];
  logic got_bits [1:260];

  // Bit clock.
  always #5 clk = ~clk;

  tx_pattern_gen dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mode    (mode),
    .nbits   (nbits),
    .stop    (stop),
    .err_inj (err_inj),
    .out     (out),
    .busy    (busy),
    .done    (done),
    .bit_cnt (bit_cnt)
  );

  // Single comparison point.
  task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare all four outputs against expected values.
  task automatic checkOutput(input string tag, input logic e_out, input logic e_busy,
                             input logic e_done, input logic [15:0] e_cnt);
    checkVal({tag, ".out"},     16'(out),  16'(e_out));
    checkVal({tag, ".busy"},    16'(busy), 16'(e_busy));
    checkVal({tag, ".done"},    16'(done), 16'(e_done));
    checkVal({tag, ".bit_cnt"}, bit_cnt,   e_cnt);
  endtask

  // Drive one cycle of inputs, then advance to the next sampling point.
  task automatic applyStimulus(input logic s, input logic [1:0] m, input logic [15:0] n,
                               input logic st, input logic e);
    start   = s;
    mode    = m;
    nbits   = n;
    stop    = st;
    err_inj = e;
    @(negedge clk);
  endtask

  // Eight-bit clock-pattern run with err_inj on the bits set in errmask
  // (bit 7 = first emitted bit) and a stray start mid-run.
  task automatic clockRun(input string tag, input logic [7:0] expv, input logic [7:0] errmask);
    applyStimulus(1'b1, 2'b11, 16'd8, 1'b0, 1'b0);
    for (int n = 1; n <= 8; n++) begin
      applyStimulus(n == 2, 2'b10, 16'd3, 1'b0, errmask[8-n]);
      checkOutput($sformatf("%s_b%0d", tag, n), expv[8-n], 1'b1, 1'b0, 16'(n));
    end
    applyStimulus(1'b0, 2'b00, 16'd0, 1'b0, 1'b0);
    checkOutput({tag, "_done"}, 1'b0, 1'b0, 1'b1, 16'd8);
    applyStimulus(1'b0, 2'b00, 16'd0, 1'b0, 1'b0);
    checkOutput({tag, "_after"}, 1'b0, 1'b0, 1'b0, 16'd8);
  endtask

  // Watchdog so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  // Directed sequence.
  initial begin
    logic [6:0] r;
    logic [6:0] first7;
    logic [6:0] exp7;
    int         ones;
    int         runlen;
    int         maxrun;
    int         permis;

    // PRBS7 reference from seed 7F: b = r[6]^r[5], r = {r[5:0], b}.
    r = 7'h7F;
    for (int i = 1; i <= 300; i++) begin
      ref_bits[i] = r[6] ^ r[5];
      r = {r[5:0], ref_bits[i]};
    end
    exp7 = 7'b0000001;

    rst = 1'b1;
    start = 1'b0; mode = 2'b00; nbits = 16'd0; stop = 1'b0; err_inj = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset", 1'b0, 1'b0, 1'b0, 16'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 2'b00, 16'd0, 1'b0, 1'b0);
    checkOutput("idle", 1'b0, 1'b0, 1'b0, 16'd0);

    // start with mode 00 and stop while idle are both ignored.
    applyStimulus(1'b1, 2'b00, 16'd4, 1'b0, 1'b0);
    checkOutput("mode00", 1'b0, 1'b0, 1'b0, 16'd0);
    applyStimulus(1'b0, 2'b00, 16'd0, 1'b1, 1'b0);
    checkOutput("stop_idle", 1'b0, 1'b0, 1'b0, 16'd0);

    // Single pulse: launch edge k, pulse after k+26, done after k+27.
    applyStimulus(1'b1, 2'b01, 16'd0, 1'b0, 1'b0);
    checkOutput("pulse_k", 1'b0, 1'b0, 1'b0, 16'd0);
    for (int n = 1; n <= 28; n++) begin
      applyStimulus((n == 3) || (n == 20) || (n == 27), 2'b11, 16'd5, 1'b0, 1'b0);
      checkOutput($sformatf("pulse_n%0d", n), n == 26, n <= 26, n == 27,
                  (n >= 26) ? 16'd1 : 16'd0);
    end

    // Continuous PRBS7, two full periods, then stop.
    applyStimulus(1'b1, 2'b10, 16'd0, 1'b0, 1'b0);
    checkOutput("prbs_k", 1'b0, 1'b0, 1'b0, 16'd0);
    for (int n = 1; n <= 254; n++) begin
      applyStimulus(1'b0, 2'b10, 16'd0, 1'b0, 1'b0);
      got_bits[n] = out;
      checkVal($sformatf("prbs_bit%0d", n), 16'(out), 16'(ref_bits[n]));
      checkVal($sformatf("prbs_busy%0d", n), 16'(busy), 16'd1);
      checkVal($sformatf("prbs_cnt%0d", n), bit_cnt, 16'(n));
    end
    for (int n = 1; n <= 7; n++) first7[7-n] = got_bits[n];
    checkVal("prbs_first7", 16'(first7), 16'(exp7));
    permis = 0;
    ones = 0;
    for (int n = 1; n <= 127; n++) begin
      if (got_bits[n] !== got_bits[n+127]) permis++;
      if (got_bits[n] === 1'b1) ones++;
    end
    checkVal("prbs_period_diffs", 16'(permis), 16'd0);
    checkVal("prbs_ones", 16'(ones), 16'd64);
    runlen = 0;
    maxrun = 0;
    for (int n = 1; n <= 254; n++) begin
      runlen = (got_bits[n] === 1'b1) ? runlen + 1 : 0;
      if (runlen > maxrun) maxrun = runlen;
    end
    checkVal("prbs_maxrun", 16'(maxrun), 16'd7);
    applyStimulus(1'b0, 2'b10, 16'd0, 1'b1, 1'b0);
    checkOutput("prbs_stop", 1'b0, 1'b0, 1'b1, 16'd254);
    applyStimulus(1'b0, 2'b10, 16'd0, 1'b0, 1'b0);
    checkOutput("prbs_hold", 1'b0, 1'b0, 1'b0, 16'd254);

    // PRBS with one injected error, then reset mid-run and restart.
    applyStimulus(1'b1, 2'b10, 16'd0, 1'b0, 1'b0);
    for (int n = 1; n <= 10; n++) begin
      applyStimulus(1'b0, 2'b10, 16'd0, 1'b0, n == 4);
      checkOutput($sformatf("inj_b%0d", n), ref_bits[n] ^ (n == 4), 1'b1, 1'b0, 16'(n));
    end
    rst = 1'b1;
    applyStimulus(1'b0, 2'b10, 16'd0, 1'b0, 1'b0);
    checkOutput("rst_mid", 1'b0, 1'b0, 1'b0, 16'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 2'b10, 16'd0, 1'b0, 1'b0);
    checkOutput("rst_after", 1'b0, 1'b0, 1'b0, 16'd0);
    applyStimulus(1'b1, 2'b10, 16'd0, 1'b0, 1'b0);
    for (int n = 1; n <= 7; n++) begin
      applyStimulus(1'b0, 2'b10, 16'd0, 1'b0, 1'b0);
      checkOutput($sformatf("restart_b%0d", n), exp7[7-n], 1'b1, 1'b0, 16'(n));
    end
    applyStimulus(1'b0, 2'b10, 16'd0, 1'b1, 1'b0);
    checkOutput("restart_stop", 1'b0, 1'b0, 1'b1, 16'd7);

    // Clock pattern, 8 bits, error on bit 3 only, then on bits 3 and 4.
    clockRun("clk1", 8'b10001010, 8'b00100000);
    clockRun("clk2", 8'b10011010, 8'b00110000);

    // PRBS nbits=20 with stop on the edge that would emit bit 20.
    applyStimulus(1'b1, 2'b10, 16'd20, 1'b0, 1'b0);
    for (int n = 1; n <= 19; n++) begin
      applyStimulus(1'b0, 2'b10, 16'd20, 1'b0, 1'b0);
      checkOutput($sformatf("n20_b%0d", n), ref_bits[n], 1'b1, 1'b0, 16'(n));
    end
    applyStimulus(1'b0, 2'b10, 16'd20, 1'b1, 1'b0);
    checkOutput("n20_stop", 1'b0, 1'b0, 1'b1, 16'd19);
    applyStimulus(1'b0, 2'b10, 16'd20, 1'b0, 1'b0);
    checkOutput("n20_after1", 1'b0, 1'b0, 1'b0, 16'd19);
    applyStimulus(1'b0, 2'b10, 16'd20, 1'b0, 1'b0);
    checkOutput("n20_after2", 1'b0, 1'b0, 1'b0, 16'd19);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
